// File: rtl/branch_predictor_if.sv
// Fetch/decode connection to the branch target buffer: lookup request and
// prediction, resolved-branch update, misprediction flag and perf counters.
interface branch_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int PERF_W = 16
);
  logic [ADDR_W-1:0] lookup_pc_i;
  logic              pred_hit_o;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_target_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_is_jump_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_pred_taken_i;
  logic [ADDR_W-1:0] upd_pred_target_i;
  logic              mispred_o;
  logic [PERF_W-1:0] upd_count_o;
  logic [PERF_W-1:0] mispred_count_o;

  // pipeline side: issues lookups and updates, consumes predictions
  modport master (
    output lookup_pc_i, upd_valid_i, upd_pc_i, upd_is_jump_i, upd_taken_i,
           upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    input  pred_hit_o, pred_taken_o, pred_target_o, mispred_o,
           upd_count_o, mispred_count_o
  );

  // predictor side
  modport slave (
    input  lookup_pc_i, upd_valid_i, upd_pc_i, upd_is_jump_i, upd_taken_i,
           upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    output pred_hit_o, pred_taken_o, pred_target_o, mispred_o,
           upd_count_o, mispred_count_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from the current table; updates land at the clock
// edge, so a same-cycle lookup of the entry being updated sees old contents.
module branch_predictor #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4,
  parameter int PERF_W = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = ADDR_W - IDX_W - 2;

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [ADDR_W-1:0] target_r [ENTRIES];
  logic              jump_r   [ENTRIES];
  logic [1:0]        cnt_r    [ENTRIES];

  logic              mispred_r;
  logic [PERF_W-1:0] upd_count_r;
  logic [PERF_W-1:0] mis_count_r;

  logic [IDX_W-1:0]  lk_idx_s;
  logic [TAG_W-1:0]  lk_tag_s;
  logic              lk_hit_s;
  logic              lk_taken_s;
  logic [ADDR_W-1:0] lk_target_s;

  logic [IDX_W-1:0]  up_idx_s;
  logic [TAG_W-1:0]  up_tag_s;
  logic              up_hit_s;
  logic [1:0]        cnt_next_s;
  logic              mispred_s;

  // instruction alignment bits never take part in index or tag
  logic unused_pc_bits_s;
  assign unused_pc_bits_s = ^{bp.lookup_pc_i[1:0], bp.upd_pc_i[1:0]};

  // fetch-side lookup: hit, direction and next-PC guess from current table
  always_comb begin
    lk_idx_s   = bp.lookup_pc_i[IDX_W+1:2];
    lk_tag_s   = bp.lookup_pc_i[ADDR_W-1:IDX_W+2];
    lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    lk_taken_s = lk_hit_s && (jump_r[lk_idx_s] || cnt_r[lk_idx_s][1]);
    if (lk_taken_s) begin
      lk_target_s = target_r[lk_idx_s];
    end else begin
      lk_target_s = bp.lookup_pc_i + ADDR_W'(4);
    end
  end

  assign bp.pred_hit_o    = lk_hit_s;
  assign bp.pred_taken_o  = lk_taken_s;
  assign bp.pred_target_o = lk_target_s;

  // update-side decode: entry match, next counter value, misprediction
  always_comb begin
    up_idx_s = bp.upd_pc_i[IDX_W+1:2];
    up_tag_s = bp.upd_pc_i[ADDR_W-1:IDX_W+2];
    up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
    if (bp.upd_taken_i) begin
      if (cnt_r[up_idx_s] == 2'b11) begin
        cnt_next_s = 2'b11;
      end else begin
        cnt_next_s = cnt_r[up_idx_s] + 2'b01;
      end
    end else begin
      if (cnt_r[up_idx_s] == 2'b00) begin
        cnt_next_s = 2'b00;
      end else begin
        cnt_next_s = cnt_r[up_idx_s] - 2'b01;
      end
    end
    mispred_s = (bp.upd_pred_taken_i != bp.upd_taken_i) ||
                (bp.upd_pred_taken_i && bp.upd_taken_i &&
                 (bp.upd_pred_target_i != bp.upd_target_i));
  end

  // table write: train on hit, allocate on taken miss, clear state on reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        jump_r[i]  <= 1'b0;
        cnt_r[i]   <= 2'b00;
      end
    end else if (bp.upd_valid_i) begin
      if (up_hit_s) begin
        cnt_r[up_idx_s]  <= cnt_next_s;
        jump_r[up_idx_s] <= bp.upd_is_jump_i;
        if (bp.upd_taken_i) begin
          target_r[up_idx_s] <= bp.upd_target_i;
        end
      end else if (bp.upd_taken_i) begin
        valid_r[up_idx_s]  <= 1'b1;
        tag_r[up_idx_s]    <= up_tag_s;
        target_r[up_idx_s] <= bp.upd_target_i;
        jump_r[up_idx_s]   <= bp.upd_is_jump_i;
        cnt_r[up_idx_s]    <= 2'b10;
      end
    end
  end

  // misprediction pulse and saturating performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mispred_r   <= 1'b0;
      upd_count_r <= {PERF_W{1'b0}};
      mis_count_r <= {PERF_W{1'b0}};
    end else begin
      mispred_r <= bp.upd_valid_i && mispred_s;
      if (bp.upd_valid_i && (upd_count_r != {PERF_W{1'b1}})) begin
        upd_count_r <= upd_count_r + PERF_W'(1);
      end
      if (bp.upd_valid_i && mispred_s && (mis_count_r != {PERF_W{1'b1}})) begin
        mis_count_r <= mis_count_r + PERF_W'(1);
      end
    end
  end

  assign bp.mispred_o       = mispred_r;
  assign bp.upd_count_o     = upd_count_r;
  assign bp.mispred_count_o = mis_count_r;
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with per-entry 2-bit saturating counters, giving the fetch stage a next-PC guess for branches and jumps. Fetch looks up its PC combinationally each cycle; the decode stage, where branches and jumps resolve, sends one update per resolved control instruction. The block also flags mispredictions and keeps saturating performance counters.

## Interface
- ADDR_W, 32, PC/target width in bits
- IDX_W, 4, index width; table holds 2^IDX_W entries
- PERF_W, 16, width of the performance counters
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- lookup_pc_i  in  ADDR_W  fetch-stage PC
- pred_hit_o  out  1  lookup PC matches a valid entry
- pred_taken_o  out  1  predicted taken
- pred_target_o  out  ADDR_W  predicted next PC
- upd_valid_i  in  1  resolved branch/jump this cycle
- upd_pc_i  in  ADDR_W  PC of the resolved instruction
- upd_is_jump_i  in  1  unconditional jump
- upd_taken_i  in  1  actual outcome
- upd_target_i  in  ADDR_W  actual target; meaningful only when taken
- upd_pred_taken_i  in  1  prediction made for this instruction at fetch
- upd_pred_target_i  in  ADDR_W  predicted target made at fetch
- mispred_o  out  1  one-cycle pulse: previous-cycle update was mispredicted
- upd_count_o  out  PERF_W  number of accepted updates
- mispred_count_o  out  PERF_W  number of mispredictions

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- Each entry holds valid, tag, target[ADDR_W], jump bit and cnt[1:0].
- Lookup is purely combinational from the current table state:
  - hit = valid && tag match.
  - pred_taken_o = hit && (jump || cnt[1]).
  - pred_target_o = the stored target when pred_taken_o = 1, otherwise lookup_pc_i + 4. Width is ADDR_W; the addition wraps modulo 2^ADDR_W.
- Update on upd_valid_i = 1, hit on the indexed entry:
  - cnt = taken ? min(cnt+1, 3) : max(cnt-1, 0).
  - If taken, target is overwritten with upd_target_i.
  - jump is set to upd_is_jump_i.
- Update on upd_valid_i = 1, miss:
  - If taken, allocate: valid=1, write the new tag, target, jump, and cnt=2'b10. This replaces any entry with a different tag.
  - If not taken, the table is unchanged.
- Misprediction: (upd_pred_taken_i != upd_taken_i), or (both are 1 and upd_pred_target_i != upd_target_i).
  - mispred_o is registered; it is asserted in the cycle after the update.
- upd_count_o increments on every accepted update. mispred_count_o increments on every mispredicted update. Both saturate at all-ones and never wrap.

## Timing
- Lookup: 0-cycle latency. Update: written at the edge ending the update cycle and visible to lookups in the next cycle.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents.
- Reset (rst_i = 1 at an edge):
  - All valid bits, cnt and jump bits are cleared, and both counters are set to 0.
  - mispred_o is set to 0.
  - Target/tag storage need not be cleared.
- Outputs after reset: pred_hit_o = 0, pred_taken_o = 0, pred_target_o = lookup_pc_i + 4.
- An update presented in a reset cycle is ignored: no table write, no count, no mispred_o.
- Reset mid-operation discards all learned state in one cycle; there is no multi-cycle clear sequence.
- One update per cycle at most. Back-to-back updates to the same entry apply in order.

## Test plan
- Reset, then look up 0x0000_0040 -> hit=0, taken=0, target=0x0000_0044, both counters 0, mispred_o=0.
- Update pc=0x40, taken=1, target=0x100, pred_taken=0 -> next cycle: lookup 0x40 gives hit=1, taken=1, target=0x100; mispred_o=1 for one cycle; upd_count=1, mispred_count=1.
- Counter hysteresis at pc=0x40:
  - Two not-taken updates -> cnt goes 2→1→0 and taken=0.
  - One taken update -> cnt=1, still not taken.
  - A second taken update -> cnt=2, taken=1.
  - A third taken update -> cnt=3; a further taken update -> cnt stays 3.
- Aliasing, IDX_W=4: allocate 0x40, then a taken update at 0x440 (same index, different tag) -> lookup 0x40 misses, lookup 0x440 hits with its own target. A not-taken update to an unallocated PC leaves the table unchanged.
- Jump entry: update with is_jump=1, taken=1, then three not-taken-direction updates with is_jump=1 -> pred_taken stays 1. Same-cycle lookup of the index being updated returns the old entry.
- Counters and reset:
  - Force PERF_W=4 and apply 20 mispredicted updates -> both counters stick at 15.
  - Assert rst_i together with an update -> the table is cleared, counters are 0, and the update is lost.
